// File: rtl/vga_sync_ctrl_if.sv
// vga_sync_ctrl_if: run request, line number and timing outputs exchanged with the VGA sync controller
interface vga_sync_ctrl_if;
  logic       Enable;
  logic [9:0] cntVertical;
  logic       vflag;
  logic       pix_tick;
  logic [9:0] hcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       busy;
  modport master (
    output Enable, cntVertical,
    input  vflag, pix_tick, hcount, hsync, vsync, video_on, frame_start, busy
  );
  modport slave (
    input  Enable, cntVertical,
    output vflag, pix_tick, hcount, hsync, vsync, video_on, frame_start, busy
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: pixel divider, horizontal counter, vertical advance strobe and sync decode with frame-aligned start/stop
module vga_sync_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input logic            Clk,
  input logic            Reset,
  vga_sync_ctrl_if.slave bus
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_div;
  logic [9:0]    r_hcount;
  logic          w_busy;
  logic          w_pix_tick;
  logic          w_vflag;
  logic          w_frame_start;
  logic          w_hsync;
  logic          w_vsync;
  logic          w_video_on;
  // state register
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: stopping only completes on the frame wrap so the vertical counter is left at line 0
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = bus.Enable ? RUN : IDLE;
      RUN:      w_next = bus.Enable ? RUN : STOPPING;
      STOPPING: w_next = bus.Enable ? RUN : w_frame_start ? IDLE : STOPPING;
      default:  w_next = IDLE;
    endcase
  end
  // outputs: strobes and sync decodes straight from registered state and the incoming line number
  always_comb begin
    w_busy        = r_state != IDLE;
    w_pix_tick    = w_busy && r_div == DIV_LAST;
    w_vflag       = w_pix_tick && r_hcount == H_LAST;
    w_frame_start = w_vflag && bus.cntVertical == V_LAST;
    w_hsync       = !(w_busy && r_hcount >= HS_BEG && r_hcount <= HS_END);
    w_vsync       = !(w_busy && bus.cntVertical >= VS_BEG && bus.cntVertical <= VS_END);
    w_video_on    = w_busy && r_hcount < H_VIS && bus.cntVertical < V_VIS;
  end
  // pixel divider and horizontal counter; both parked at 0 while idle
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_div    <= '0;
      r_hcount <= '0;
    end else if (!w_busy) begin
      r_div    <= '0;
      r_hcount <= '0;
    end else begin
      r_div <= w_pix_tick ? '0 : r_div + 1'b1;
      if (w_pix_tick) r_hcount <= r_hcount == H_LAST ? '0 : r_hcount + 10'd1;
    end
  assign bus.busy        = w_busy;
  assign bus.pix_tick    = w_pix_tick;
  assign bus.vflag       = w_vflag;
  assign bus.frame_start = w_frame_start;
  assign bus.hsync       = w_hsync;
  assign bus.vsync       = w_vsync;
  assign bus.video_on    = w_video_on;
  assign bus.hcount      = r_hcount;
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: random run/stop and line-number stimulus on a small-geometry controller checked against a cycle-position model, plus literal timing checks on a default-geometry controller
module tb_vga_sync_ctrl;
  localparam int D = 2, HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int LINE = D * HT;

  logic Clk = 0;
  logic S_rst = 1;
  logic B_rst = 1;
  always #5 Clk = ~Clk;

  vga_sync_ctrl_if sb();
  vga_sync_ctrl_if bb();

  vga_sync_ctrl #(.CLK_DIV(D), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_small (.Clk(Clk), .Reset(S_rst), .bus(sb.slave));
  vga_sync_ctrl u_big (.Clk(Clk), .Reset(B_rst), .bus(bb.slave));

  int checks = 0;
  int fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // vertical line counter fed by the small controller's advance strobe, optionally overridden
  logic [9:0] vcnt;
  logic       ovr = 0;
  logic [9:0] ovr_val = 0;
  always @(posedge Clk or posedge S_rst)
    if (S_rst) vcnt <= '0;
    else if (sb.vflag) vcnt <= (vcnt == 10'(VT - 1)) ? 10'd0 : vcnt + 10'd1;
  assign sb.cntVertical = ovr ? ovr_val : vcnt;
  assign bb.cntVertical = '0;

  // reference model: position in line counted in raw clocks since start
  logic rst_edge = 1;
  always @(posedge Clk) rst_edge <= S_rst;
  bit m_busy = 0, m_stop = 0, p_en = 0, p_fs = 0;
  int m_t = 0;
  always @(negedge Clk) begin
    int hc, cnt;
    bit e_pt, e_vf, e_fs, e_hs, e_vs, e_vo;
    #2;
    if (S_rst || rst_edge) begin
      m_busy = 0; m_stop = 0; m_t = 0;
    end else if (!m_busy) begin
      m_busy = p_en; m_t = 0;
    end else begin
      m_t = (m_t + 1) % LINE;
      if (p_en) m_stop = 0;
      else if (m_stop && p_fs) begin m_busy = 0; m_stop = 0; end
      else m_stop = 1;
    end
    hc = m_t / D;
    cnt = int'(sb.cntVertical);
    e_pt = m_busy && (m_t % D == D - 1);
    e_vf = m_busy && m_t == LINE - 1;
    e_fs = e_vf && cnt == VT - 1;
    e_hs = !(m_busy && hc >= HD + HF && hc < HD + HF + HS);
    e_vs = !(m_busy && cnt >= VD + VF && cnt < VD + VF + VS);
    e_vo = m_busy && hc < HD && cnt < VD;
    check("outputs", {15'd0, sb.busy, sb.pix_tick, sb.vflag, sb.frame_start, sb.hsync, sb.vsync, sb.video_on, sb.hcount},
          {15'd0, m_busy, e_pt, e_vf, e_fs, e_hs, e_vs, e_vo, 10'(hc)});
    p_en = sb.Enable;
    p_fs = e_fs;
  end

  int vf_cnt = 0, fs_cnt = 0;
  bit fell = 0;
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk); #1;
      if (sb.vflag) vf_cnt++;
      if (sb.frame_start) fs_cnt++;
      if (!sb.busy) fell = 1;
    end
  endtask

  task automatic wait_pos(input int line, input int hc, input string name);
    int n = 0;
    while (!(int'(vcnt) == line && int'(sb.hcount) == hc) && n < 2 * VT * LINE) begin tick(1); n++; end
    check({name, "_reach"}, 32'(int'(vcnt) == line && int'(sb.hcount) == hc), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.busy && n < 3 * VT * LINE) begin tick(1); n++; end
    check({name, "_idle"}, 32'(sb.busy), 0);
  endtask

  task automatic restart_check(input string name);
    int fp = -1, fv = -1;
    for (int c = 0; c <= LINE; c++) begin
      tick(1);
      if (sb.pix_tick && fp < 0) fp = c;
      if (sb.vflag && fv < 0) fv = c;
      if (c == 0) check({name, "_busy"}, 32'(sb.busy), 1);
      if (c == LINE) begin
        check({name, "_hwrap"}, 32'(sb.hcount), 0);
        check({name, "_vadv"}, 32'(vcnt), 1);
      end
    end
    check({name, "_first_pix"}, fp, D - 1);
    check({name, "_first_vflag"}, fv, LINE - 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(sb.busy), 0);
    check({name, "_hcount"}, 32'(sb.hcount), 0);
    check({name, "_hsync"}, 32'(sb.hsync), 1);
    check({name, "_vsync"}, 32'(sb.vsync), 1);
    check({name, "_video_on"}, 32'(sb.video_on), 0);
    check({name, "_pix_tick"}, 32'(sb.pix_tick), 0);
    check({name, "_vflag"}, 32'(sb.vflag), 0);
    check({name, "_frame_start"}, 32'(sb.frame_start), 0);
    check({name, "_vcnt"}, 32'(vcnt), 0);
  endtask

  bit big_done = 0;
  int b_fp, b_fv, b_vf, b_pt, b_hs, b_vo, b_vs, b_fs;
  initial begin
    b_fp = -1; b_fv = -1; b_vf = 0; b_pt = 0; b_hs = 0; b_vo = 0; b_vs = 0; b_fs = 0;
    bb.Enable = 0;
    repeat (2) @(negedge Clk);
    #1;
    check("big_reset_busy", 32'(bb.busy), 0);
    check("big_reset_hsync", 32'(bb.hsync), 1);
    B_rst = 0;
    bb.Enable = 1;
    for (int c = 0; c <= 3200; c++) begin
      @(negedge Clk); #1;
      if (c <= 3199) begin
        if (bb.pix_tick) begin b_pt++; if (b_fp < 0) b_fp = c; end
        if (bb.vflag) begin b_vf++; if (b_fv < 0) b_fv = c; end
        if (!bb.hsync) b_hs++;
        if (bb.video_on) b_vo++;
        if (!bb.vsync) b_vs++;
        if (bb.frame_start) b_fs++;
      end
      if (c == 3199) check("big_hcount_last", 32'(bb.hcount), 799);
      if (c == 3200) check("big_hcount_wrap", 32'(bb.hcount), 0);
    end
    check("big_first_pix", b_fp, 3);
    check("big_first_vflag", b_fv, 3199);
    check("big_vflag_count", b_vf, 1);
    check("big_pix_count", b_pt, 800);
    check("big_hsync_low", b_hs, 384);
    check("big_video_on", b_vo, 2560);
    check("big_vsync_low", b_vs, 0);
    check("big_frame_start", b_fs, 0);
    big_done = 1;
  end

  initial begin
    int n;
    sb.Enable = 0;
    tick(3);
    check_idle_outputs("reset");
    S_rst = 0;
    tick(2);
    check("idle_hold_busy", 32'(sb.busy), 0);
    sb.Enable = 1;
    restart_check("start");
    fs_cnt = 0;
    tick(VT * LINE);
    check("frame_pulses", fs_cnt, 1);
    wait_pos(3, 0, "stop");
    vf_cnt = 0; fs_cnt = 0;
    sb.Enable = 0;
    wait_idle("stop");
    check("stop_vflags", vf_cnt, VT - 3);
    check("stop_frame_start", fs_cnt, 1);
    check_idle_outputs("stopped");
    sb.Enable = 1;
    wait_pos(2, 0, "gap_drop");
    vf_cnt = 0; fell = 0;
    sb.Enable = 0;
    wait_pos(5, 0, "gap_raise");
    sb.Enable = 1;
    tick(LINE);
    check("gap_no_fall", 32'(fell), 0);
    check("gap_vflags", vf_cnt, 4);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) sb.Enable = ~sb.Enable;
      ovr = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: ovr_val = 10'(VT - 1);
        1: ovr_val = 10'($urandom_range(0, VT - 1));
        default: ovr_val = 10'($urandom_range(VT, 1023));
      endcase
      tick(1);
    end
    ovr = 0;
    sb.Enable = 1;
    wait_pos(5, 8, "async");
    @(posedge Clk);
    #2 S_rst = 1;
    #1 check_idle_outputs("async_reset");
    tick(2);
    S_rst = 0;
    sb.Enable = 1;
    restart_check("restart");
    sb.Enable = 0;
    wait_idle("final");
    n = 0;
    while (!big_done && n < 5000) begin tick(1); n++; end
    check("big_done", 32'(big_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Timing controller that sequences the 525-line vertical counter (`contadorvertical`) of the VGA output path. It divides the system clock into a pixel tick, runs the 800-pixel horizontal counter, and issues the one-cycle `vflag` advance strobe to the vertical counter. It also decodes `hsync`, `vsync` and `video_on` from its own horizontal count and the vertical counter's `cntVertical`. Start and stop are frame-aligned, so the vertical counter is always left at line 0 when the display is halted.

## Interface
- CLK_DIV, 4: system clocks per pixel (≥2)
- H_DISP, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_DISP, 480: visible lines
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines. V_DISP+V_FP+V_SYNC+V_BP = 525 matches the vertical counter wrap.

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Enable  in  1  run request, level-sensitive
- cntVertical  in  10  current line from the vertical counter
- vflag  out  1  one-Clk advance strobe to the vertical counter
- pix_tick  out  1  one-Clk pulse per pixel
- hcount  out  10  current pixel, 0..H_TOTAL-1 (H_TOTAL = 800)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high inside the visible area
- frame_start  out  1  one-Clk pulse on the 524→0 line wrap
- busy  out  1  high in RUN or STOPPING

## Operation
- FSM states: IDLE, RUN, STOPPING. Reset forces IDLE.
  - IDLE→RUN when Enable=1.
  - RUN→STOPPING when Enable=0.
  - STOPPING→RUN when Enable=1.
  - STOPPING→IDLE on the edge where `frame_start` fires.
- Divider `div`, 0..CLK_DIV-1:
  - Counts only in RUN or STOPPING.
  - Held at 0 in IDLE.
  - `pix_tick` = busy && div==CLK_DIV-1 (combinational from the registered div).
- `hcount` increments on `pix_tick` and wraps 799→0. It is held at 0 in IDLE.
- `vflag` = pix_tick && hcount==799, so the vertical counter advances on the same edge that hcount wraps.
- `frame_start` = vflag && cntVertical==V_TOTAL-1 (524).
- `hsync` = 0 iff busy && hcount in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], i.e. 656..751.
- `vsync` = 0 iff busy && cntVertical in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1], i.e. 490..491.
- `video_on` = busy && hcount<H_DISP && cntVertical<V_DISP.
- All decodes are combinational from registered state and `cntVertical`. They carry no added pipeline delay.
- `cntVertical` ≥ 525 is treated as non-visible, non-sync. `frame_start` never fires for such a value.

## Timing
- Reset values: state IDLE, div 0, hcount 0, vflag 0, pix_tick 0, frame_start 0, busy 0, hsync 1, vsync 1, video_on 0.
- Start: Enable sampled high at edge k → busy=1 after edge k.
  - First pix_tick is during the cycle after edge k+CLK_DIV-1.
  - First vflag occurs 800·CLK_DIV cycles after edge k.
- Stop: the line and frame in progress complete. Every vflag in STOPPING is still issued.
  - The final vflag coincides with frame_start.
  - After that edge the state is IDLE, the vertical counter reads 0, and hcount is 0.
- Enable toggled low→high within STOPPING: no gap, no reset of div or hcount.
- Asynchronous Reset mid-line: all outputs take their reset values immediately, without waiting for a clock edge. The vertical counter shares Reset, so both return to 0 together.
- Line period is 800·CLK_DIV Clk cycles. Frame period is 525·800·CLK_DIV Clk cycles (1 680 000 at CLK_DIV=4).

## Test plan
- Reset then Enable=1 at edge 0 (CLK_DIV=4): pix_tick first high cycle 3, then every 4 cycles; vflag first high at cycle 3199, width 1; hcount 799→0 on that edge.
- Full line with cntVertical=0: hsync low exactly for hcount 656..751 (384 Clk); video_on high for hcount 0..639; vsync stays 1.
- Full frame driving a real vertical counter: vsync low for lines 490–491 only; frame_start a single pulse when cntVertical=524 and hcount=799; period 1 680 000 Clk.
- Enable dropped at line 100: lines continue to 524, vflag issued each line, IDLE entered with frame_start; afterwards cntVertical=0, hcount=0, hsync=vsync=1, busy=0.
- Enable dropped at line 200 and re-raised at line 300: busy never falls; no hcount discontinuity; no extra or missing vflag.
- Reset asserted asynchronously at hcount=400, line 250: outputs take reset values before the next Clk edge; after release with Enable=1, restart timing matches the first scenario.
